// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and a constant
// helper used to size the shared phase counter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT    = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Debounces the raw PLL lock: lock_ok is high once locked has been seen high
// for LOCK_FILTER_CYCLES consecutive cycles while clr is low.
module lock_filter #(
  parameter int LOCK_FILTER_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic locked,
  output logic lock_ok
);

  localparam int           W      = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam logic [W-1:0] TARGET = W'(LOCK_FILTER_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !locked) begin
      cnt_d = '0;
    end else if (cnt_q != TARGET) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lock_ok = (cnt_q == TARGET);

endmodule

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: waits for a filtered PLL lock, holds all
// resets, then releases channels in staggered order; re-arms on lock loss.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int N_CH               = 3,
  parameter int MIN_ASSERT_CYCLES  = 16,
  parameter int LOCK_FILTER_CYCLES = 64,
  parameter int HOLD_CYCLES        = 2000000,
  parameter int STAGGER_CYCLES     = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            locked,
  input  logic            soft_rst_req,
  output logic [N_CH-1:0] rst_out,
  output logic [N_CH-1:0] rstn_out,
  output logic            all_released,
  output state_t          state_o,
  output logic [7:0]      relock_cnt
);

  localparam int CNT_W = $clog2(max(max(MIN_ASSERT_CYCLES, LOCK_FILTER_CYCLES),
                                    max(HOLD_CYCLES, STAGGER_CYCLES)) + 1);
  localparam int REL_W = $clog2(N_CH + 1);

  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);

  // With one channel or no stagger every channel clears on the RELEASE entry edge,
  // so the sequencer goes straight to RUN on that edge.
  localparam bit               DIRECT_RUN = (N_CH == 1) || (STAGGER_CYCLES == 0);
  localparam logic [REL_W-1:0] REL_ALL    = REL_W'(N_CH);
  localparam logic [REL_W-1:0] REL_FIRST  = DIRECT_RUN ? REL_ALL : REL_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic [REL_W-1:0]  rel_inc;
  logic [7:0]        relock_q, relock_d;
  logic [N_CH-1:0]   rst_out_q, rst_out_d;
  logic [N_CH-1:0]   rstn_q;
  logic              all_rel_q;
  logic              lock_ok;
  logic              lock_lost;

  lock_filter #(
    .LOCK_FILTER_CYCLES(LOCK_FILTER_CYCLES)
  ) u_lock_filter (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != WAIT_LOCK),
    .locked  (locked),
    .lock_ok (lock_ok)
  );

  assign rel_inc   = rel_q + REL_W'(1);
  assign lock_lost = !locked && (state_q == HOLD || state_q == RELEASE || state_q == RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    relock_d = relock_q;

    case (state_q)
      ASSERT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MIN_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HOLD_LAST) begin
          state_d = DIRECT_RUN ? RUN : RELEASE;
          cnt_d   = '0;
          rel_d   = REL_FIRST;
        end
      end
      RELEASE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == STG_LAST) begin
          cnt_d = '0;
          rel_d = rel_inc;
          if (rel_inc == REL_ALL) begin
            state_d = RUN;
          end
        end
      end
      RUN: ;
      default: begin
        state_d = ASSERT;
        cnt_d   = '0;
        rel_d   = '0;
      end
    endcase

    // Lock loss and soft requests override normal sequencing and re-arm every channel.
    if (soft_rst_req || lock_lost) begin
      state_d = ASSERT;
      cnt_d   = '0;
      rel_d   = '0;
    end
    if (lock_lost && relock_q != 8'hFF) begin
      relock_d = relock_q + 8'd1;
    end

    rst_out_d = '1;
    for (int k = 0; k < N_CH; k++) begin
      rst_out_d[k] = (k >= int'(rel_d));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      rel_q     <= '0;
      relock_q  <= '0;
      rst_out_q <= '1;
      rstn_q    <= '0;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      relock_q  <= relock_d;
      rst_out_q <= rst_out_d;
      rstn_q    <= ~rst_out_d;
      all_rel_q <= (state_d == RUN);
    end
  end

  assign rst_out      = rst_out_q;
  assign rstn_out     = rstn_q;
  assign all_released = all_rel_q;
  assign state_o      = state_q;
  assign relock_cnt   = relock_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: a 3-channel staggered build and a 1-channel no-stagger
// build share stimulus and are compared every cycle against a timing model.
module tb_rst_seq_gen;
  import rst_seq_pkg::*;

  localparam int MIN_A  = 4;
  localparam int LF     = 8;
  localparam int HOLD_C = 20;
  localparam int STG    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_rst_req = 1'b0;

  logic [2:0] rst_out0, rstn_out0;
  logic       all_rel0;
  state_t     st0;
  logic [7:0] relock0;

  logic [0:0] rst_out1, rstn_out1;
  logic       all_rel1;
  state_t     st1;
  logic [7:0] relock1;

  rst_seq_gen #(
    .N_CH(3), .MIN_ASSERT_CYCLES(MIN_A), .LOCK_FILTER_CYCLES(LF),
    .HOLD_CYCLES(HOLD_C), .STAGGER_CYCLES(STG)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked), .soft_rst_req(soft_rst_req),
    .rst_out(rst_out0), .rstn_out(rstn_out0), .all_released(all_rel0),
    .state_o(st0), .relock_cnt(relock0)
  );

  rst_seq_gen #(
    .N_CH(1), .MIN_ASSERT_CYCLES(MIN_A), .LOCK_FILTER_CYCLES(LF),
    .HOLD_CYCLES(HOLD_C), .STAGGER_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .locked(locked), .soft_rst_req(soft_rst_req),
    .rst_out(rst_out1), .rstn_out(rstn_out1), .all_released(all_rel1),
    .state_o(st1), .relock_cnt(relock1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: each instance tracks its phase, edges spent in that phase and
  // the current run of locked=1 samples; released channels follow from elapsed time.
  int     n_ch[2] = '{3, 1};
  int     stg[2]  = '{STG, 0};
  state_t m_st[2];
  int     m_age[2];
  int     m_run[2];
  int     m_relock[2];
  bit     m_valid = 1'b0;
  bit     m_lost;

  function automatic logic [2:0] exp_rst(input int i);
    int rel;
    logic [2:0] mask;
    mask = 3'((1 << n_ch[i]) - 1);
    case (m_st[i])
      RELEASE: rel = 1 + m_age[i] / stg[i];
      RUN:     rel = n_ch[i];
      default: rel = 0;
    endcase
    return mask & ~3'((1 << rel) - 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i]     = ASSERT;
        m_age[i]    = 0;
        m_run[i]    = 0;
        m_relock[i] = 0;
        m_valid     = 1'b1;
      end else begin
        m_lost = !locked && (m_st[i] == HOLD || m_st[i] == RELEASE || m_st[i] == RUN);
        if (soft_rst_req || m_lost) begin
          if (m_lost && m_relock[i] < 255) m_relock[i]++;
          m_st[i]  = ASSERT;
          m_age[i] = 0;
          m_run[i] = 0;
        end else begin
          case (m_st[i])
            ASSERT:
              if (m_age[i] + 1 == MIN_A) begin
                m_st[i] = WAIT_LOCK; m_age[i] = 0; m_run[i] = 0;
              end else m_age[i]++;
            WAIT_LOCK:
              if (m_run[i] == LF) begin
                m_st[i] = HOLD; m_age[i] = 0;
              end else m_run[i] = locked ? m_run[i] + 1 : 0;
            HOLD:
              if (m_age[i] + 1 == HOLD_C) begin
                m_age[i] = 0;
                m_st[i]  = ((n_ch[i] - 1) * stg[i] == 0) ? RUN : RELEASE;
              end else m_age[i]++;
            RELEASE: begin
              m_age[i]++;
              if (m_age[i] == (n_ch[i] - 1) * stg[i]) m_st[i] = RUN;
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic [2:0] e0, ne0, e1;

  always @(negedge clk) begin
    if (m_valid) begin
      e0  = exp_rst(0);
      ne0 = ~e0;
      e1  = exp_rst(1);
      check("rst_out0", rst_out0, e0);
      check("rstn_out0", rstn_out0, ne0);
      check("all_rel0", all_rel0, m_st[0] == RUN);
      check("state0", st0, m_st[0]);
      check("relock0", relock0, m_relock[0]);
      check("rst_out1", rst_out1, e1[0]);
      check("rstn_out1", rstn_out1, !e1[0]);
      check("all_rel1", all_rel1, m_st[1] == RUN);
      check("state1", st1, m_st[1]);
      check("relock1", relock1, m_relock[1]);
    end
  end

  int t_now;

  task automatic tick();
    @(posedge clk);
    #1;
    t_now++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    t_now = -1;
  endtask

  task automatic tick_to(input int t);
    while (t_now < t) tick();
  endtask

  task automatic wait_model(input state_t s, input int budget, input string name);
    int n;
    n = 0;
    while (m_st[0] != s && n < budget) begin
      tick();
      n++;
    end
    check(name, st0, s);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;

    // Steady lock: fixed release schedule for both builds.
    locked = 1'b1;
    do_reset();
    tick_to(3);
    check("t1_wait_lock_t3", st0, WAIT_LOCK);
    tick_to(11);
    check("t1_still_wait_t11", st0, WAIT_LOCK);
    tick_to(12);
    check("t1_hold_t12", st0, HOLD);
    tick_to(31);
    check("t1_all_held_t31", rst_out0, 3'b111);
    check("t1_model_t31", exp_rst(0), 3'b111);
    check("t6_held_t31", rst_out1, 1'b1);
    check("t6_not_released_t31", all_rel1, 1'b0);
    tick_to(32);
    check("t1_ch0_t32", rst_out0, 3'b110);
    check("t1_model_t32", exp_rst(0), 3'b110);
    check("t6_release_t32", rst_out1, 1'b0);
    check("t6_all_released_t32", all_rel1, 1'b1);
    check("t6_run_t32", st1, RUN);
    tick_to(36);
    check("t1_ch1_held_t36", rst_out0, 3'b110);
    tick_to(37);
    check("t1_ch1_t37", rst_out0, 3'b100);
    tick_to(41);
    check("t1_ch2_held_t41", rst_out0, 3'b100);
    check("t1_not_released_t41", all_rel0, 1'b0);
    tick_to(42);
    check("t1_ch2_t42", rst_out0, 3'b000);
    check("t1_all_released_t42", all_rel0, 1'b1);
    check("t1_rstn_t42", rstn_out0, 3'b111);
    check("t1_model_run_t42", m_st[0], RUN);

    // Lock glitching every 6 cycles never satisfies the filter.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      locked = (k % 6 != 5);
      tick();
      check("t2_no_hold", st0 == HOLD, 1'b0);
    end
    locked = 1'b1;
    repeat (8) tick();
    check("t2_wait_after_8", st0, WAIT_LOCK);
    tick();
    check("t2_hold_after_lock", st0, HOLD);

    // Single-cycle lock loss in RUN.
    wait_model(RUN, 100, "t3_reach_run");
    check("t3_released", rst_out0, 3'b000);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    check("t3_reassert", rst_out0, 3'b111);
    check("t3_all_rel_low", all_rel0, 1'b0);
    check("t3_relock", relock0, 8'd1);
    check("t3_relock1", relock1, 8'd1);
    wait_model(RUN, 100, "t3_rerun");
    check("t3_rereleased", all_rel0, 1'b1);

    // Soft requests: from RUN, mid-RELEASE, and a restart inside ASSERT.
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t4_soft_from_run", rst_out0, 3'b111);
    n = 0;
    while (exp_rst(0) != 3'b110 && n < 100) begin
      tick();
      n++;
    end
    check("t4_reach_110", rst_out0, 3'b110);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t4_soft_mid_release", rst_out0, 3'b111);
    check("t4_relock_kept", relock0, 8'd1);
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    tick();
    tick();
    check("t4_assert_p2_plus2", st0, ASSERT);
    tick();
    check("t4_assert_p2_plus3", st0, ASSERT);
    tick();
    check("t4_wait_p2_plus4", st0, WAIT_LOCK);

    // Randomized lock-loss storm drives the relock counter into saturation.
    for (int it = 0; it < 300; it++) begin
      locked = 1'b1;
      soft_rst_req = 1'b0;
      n = 0;
      while (!(m_st[0] == HOLD || m_st[0] == RELEASE || m_st[0] == RUN) && n < 400) begin
        soft_rst_req = ($urandom_range(0, 29) == 0);
        locked = !(m_st[0] == WAIT_LOCK && $urandom_range(0, 11) == 0);
        tick();
        n++;
      end
      soft_rst_req = 1'b0;
      locked = 1'b1;
      check("t5_reach_hold", st0 == HOLD || st0 == RELEASE || st0 == RUN, 1'b1);
      repeat ($urandom_range(0, 25)) tick();
      locked = 1'b0;
      soft_rst_req = ($urandom_range(0, 3) == 0);
      tick();
      soft_rst_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      locked = 1'b1;
    end
    check("t5_relock_sat", relock0, 8'd255);
    check("t5_relock_sat1", relock1, 8'd255);
    check("t5_model_sat", m_relock[0], 255);

    // Synchronous reset from RUN.
    soft_rst_req = 1'b0;
    locked = 1'b1;
    wait_model(RUN, 200, "t5_reach_run");
    rst = 1'b1;
    tick();
    check("t5_rst_state", st0, ASSERT);
    check("t5_rst_out", rst_out0, 3'b111);
    check("t5_rstn_out", rstn_out0, 3'b000);
    check("t5_rst_all_rel", all_rel0, 1'b0);
    check("t5_rst_relock", relock0, 8'd0);
    check("t5_rst_out1", rst_out1, 1'b1);
    rst = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
